integrator_vth_v3: RTL and testbench
====================================

INTEGRATOR_VTH_V3 -- requirements
Module: integrator_vth_v3

Interface
REQ-001 SHALL have parameter ERR_W, default 32: signed error input width.
REQ-002 SHALL have parameter ACC_W, default 32: signed accumulator / output width (ACC_W >= ERR_W).
REQ-003 SHALL have parameter SHIFT_W, default 5: gain shift index width.
REQ-004 SHALL have parameter RAMP_DIV, default 4: cycles per shift step during gain ramp (>= 1).
REQ-005 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_en  input  1  accumulate enable.
REQ-008 SHALL have port i_zero  input  1  synchronous accumulator clear.
REQ-009 SHALL have port i_err  input  ERR_W  signed loop error.
REQ-010 SHALL have port i_gain_sel  input  SHIFT_W  target right-shift (gain = 2^-sel).
REQ-011 SHALL have port i_gain_mode  input  1  0 = immediate gain change, 1 = ramped.
REQ-012 SHALL have port i_saturation  input  ACC_W  unsigned per-step |dv| limit.
REQ-013 SHALL have port i_vth  input  ACC_W  unsigned accumulator threshold.
REQ-014 SHALL have port i_vth_cut_mode  input  1  0 = wrap at threshold, 1 = clamp.
REQ-015 SHALL have ports i_add_sig_en input 1 and i_ext_sig input ACC_W: signed additive output offset.
REQ-016 SHALL have port o_int  output  ACC_W  registered integrator output.
REQ-017 SHALL have ports o_sat_flag_p/o_sat_flag_n, o_vth_flag_p/o_vth_flag_n, o_change, each output 1.

Function
REQ-018 Step: dv = i_err arithmetic-shifted right by current shift index, sign-extended to ACC_W+2 bits.
REQ-019 dv > +i_saturation -> dv = +i_saturation, o_sat_flag_p = 1; dv < -i_saturation -> dv = -i_saturation, o_sat_flag_n = 1; flags registered, valid same cycle as the acc update.
REQ-020 Sum acc+dv SHALL be formed in ACC_W+2 bits; no silent overflow.
REQ-021 Wrap mode: sum >= +i_vth -> acc = sum - i_vth; sum <= -i_vth -> acc = sum + i_vth; o_vth_flag_p/n pulses 1 cycle.
REQ-022 Clamp mode: acc limited to +/-i_vth; matching o_vth_flag held high while clamped.
REQ-023 i_en = 0: acc holds, all four flags 0.
REQ-024 i_zero SHALL have priority over i_en: acc = 0 next cycle, flags 0.
REQ-025 o_int = acc + (i_add_sig_en ? i_ext_sig : 0), wrapping ACC_W, registered; latency i_err -> o_int = 2 cycles.
REQ-026 Gain FSM states IDLE, STEP, WAIT; shift index resets to 0.
REQ-027 IDLE, i_gain_sel != index: mode 0 -> index = i_gain_sel next cycle, stay IDLE; mode 1 -> STEP.
REQ-028 STEP: index moves 1 toward i_gain_sel, -> WAIT; WAIT counts RAMP_DIV-1 cycles then -> STEP, or -> IDLE when index == i_gain_sel.
REQ-029 Target change mid-ramp SHALL retarget from current index without returning to IDLE; i_gain_mode -> 0 mid-ramp jumps immediately to target, -> IDLE.
REQ-030 o_change = 1 whenever FSM != IDLE.
REQ-031 Ramp SHALL continue while i_en = 0 or i_zero = 1.

Reset
REQ-032 i_rst_n low SHALL immediately clear acc, o_int, all flags, o_change, shift index, ramp counter; FSM = IDLE, including mid-ramp.
REQ-033 First accumulation SHALL occur on the first rising edge with i_rst_n high and i_en high.

Configuration
REQ-034 Macro INT_VTH_V3_DBG_EN defined: extra outputs o_dv (ACC_W), o_acc (ACC_W), o_shift_idx (SHIFT_W), o_cstate (2) expose internal registers; undefined: ports and logic absent, functional behaviour identical.

Verification
REQ-035 err=10, sel=0, sat=1000, vth=10000, wrap: acc +10/cycle; 1000th enabled cycle acc=0, o_vth_flag_p one-cycle pulse.
REQ-036 err=5000, sel=0, sat=1000: acc +1000/cycle, o_sat_flag_p=1 every enabled cycle; err=-5000 -> -1000/cycle, o_sat_flag_n=1.
REQ-037 err=-10, sel=1, vth=10000, cut_mode=1: acc -5/cycle, holds at -10000, o_vth_flag_n stays 1.
REQ-038 gain_mode=1, RAMP_DIV=4, sel 0->2: index 1 then 2 four cycles later, o_change high 5 cycles; sel 2->0 mid-ramp retargets downward.
REQ-039 i_zero and i_en both high with acc=700 -> acc=0 next cycle; reset asserted mid-ramp -> index 0, o_change 0 immediately.
REQ-040 add_sig_en=1, ext_sig=-3, acc=20 -> o_int=17 next cycle.

Source files
------------

// File: rtl/integrator_vth_v3.sv
// Shift-gain integrator with per-step saturation, threshold wrap/clamp and ramped gain changes.
// Define INT_VTH_V3_DBG_EN to add the o_dv/o_acc/o_shift_idx/o_cstate observation ports.
module integrator_vth_v3 #(
  parameter int ERR_W    = 32,
  parameter int ACC_W    = 32,
  parameter int SHIFT_W  = 5,
  parameter int RAMP_DIV = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic                      i_zero,
  input  logic signed [ERR_W-1:0]   i_err,
  input  logic        [SHIFT_W-1:0] i_gain_sel,
  input  logic                      i_gain_mode,
  input  logic        [ACC_W-1:0]   i_saturation,
  input  logic        [ACC_W-1:0]   i_vth,
  input  logic                      i_vth_cut_mode,
  input  logic                      i_add_sig_en,
  input  logic signed [ACC_W-1:0]   i_ext_sig,
  output logic signed [ACC_W-1:0]   o_int,
  output logic                      o_sat_flag_p,
  output logic                      o_sat_flag_n,
  output logic                      o_vth_flag_p,
  output logic                      o_vth_flag_n,
  output logic                      o_change
`ifdef INT_VTH_V3_DBG_EN
  ,
  output logic signed [ACC_W-1:0]   o_dv,
  output logic signed [ACC_W-1:0]   o_acc,
  output logic        [SHIFT_W-1:0] o_shift_idx,
  output logic        [1:0]         o_cstate
`endif
);

  localparam int SW    = ACC_W + 2;
  localparam int CNT_W = $clog2(RAMP_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  function automatic logic signed [SW-1:0] clamp_step(
    input logic signed [SW-1:0] d,
    input logic signed [SW-1:0] lim
  );
    if (d > lim)       return lim;
    else if (d < -lim) return -lim;
    else               return d;
  endfunction

  function automatic logic signed [ACC_W-1:0] fold_vth(
    input logic signed [SW-1:0] s,
    input logic signed [SW-1:0] lim,
    input logic                 clamp
  );
    logic signed [SW-1:0] r;
    r = s;
    if (s >= lim)       r = clamp ? lim  : s - lim;
    else if (s <= -lim) r = clamp ? -lim : s + lim;
    return ACC_W'(r);
  endfunction

  state_t                    state_q;
  logic        [SHIFT_W-1:0] idx_q;
  logic        [SHIFT_W-1:0] idx_step;
  logic        [CNT_W-1:0]   cnt_q;
  logic                      change_q;

  logic signed [SW-1:0]      err_ext;
  logic signed [SW-1:0]      dv_raw;
  logic signed [SW-1:0]      dv;
  logic signed [SW-1:0]      sat_lim;
  logic signed [SW-1:0]      vth_lim;
  logic signed [SW-1:0]      sum;
  logic signed [ACC_W-1:0]   acc_d;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   int_q;
  logic                      sat_p_d, sat_n_d, vth_p_d, vth_n_d;
  logic                      sat_p_q, sat_n_q, vth_p_q, vth_n_q;

  // Stage 1: shift, saturate, accumulate and fold against the threshold
  assign err_ext = {{(SW-ERR_W){i_err[ERR_W-1]}}, i_err};
  assign dv_raw  = err_ext >>> idx_q;
  assign sat_lim = {2'b00, i_saturation};
  assign vth_lim = {2'b00, i_vth};
  assign dv      = clamp_step(dv_raw, sat_lim);
  assign sum     = SW'(acc_q) + dv;
  assign acc_d   = fold_vth(sum, vth_lim, i_vth_cut_mode);
  assign sat_p_d = dv_raw > sat_lim;
  assign sat_n_d = dv_raw < -sat_lim;
  assign vth_p_d = sum >= vth_lim;
  assign vth_n_d = (sum <= -vth_lim) && !vth_p_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q   <= '0;
      sat_p_q <= 1'b0;
      sat_n_q <= 1'b0;
      vth_p_q <= 1'b0;
      vth_n_q <= 1'b0;
    end else if (i_zero) begin
      acc_q   <= '0;
      sat_p_q <= 1'b0;
      sat_n_q <= 1'b0;
      vth_p_q <= 1'b0;
      vth_n_q <= 1'b0;
    end else if (i_en) begin
      acc_q   <= acc_d;
      sat_p_q <= sat_p_d;
      sat_n_q <= sat_n_d;
      vth_p_q <= vth_p_d;
      vth_n_q <= vth_n_d;
    end else begin
      sat_p_q <= 1'b0;
      sat_n_q <= 1'b0;
      vth_p_q <= 1'b0;
      vth_n_q <= 1'b0;
    end
  end

  // Stage 2: optional additive offset, wrapping at ACC_W
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      int_q <= '0;
    end else begin
      int_q <= acc_q + (i_add_sig_en ? i_ext_sig : '0);
    end
  end

  // Gain ramp: a step that lands on the target ends the ramp without another wait
  assign idx_step = (i_gain_sel > idx_q) ? idx_q + SHIFT_W'(1) : idx_q - SHIFT_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      change_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_gain_sel != idx_q) begin
            if (!i_gain_mode) begin
              idx_q <= i_gain_sel;
            end else begin
              state_q  <= S_STEP;
              change_q <= 1'b1;
            end
          end
        end
        S_STEP: begin
          if (!i_gain_mode || i_gain_sel == idx_q || idx_step == i_gain_sel) begin
            idx_q    <= i_gain_sel;
            state_q  <= S_IDLE;
            change_q <= 1'b0;
          end else begin
            idx_q    <= idx_step;
            cnt_q    <= CNT_W'(1);
            state_q  <= S_WAIT;
            change_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (!i_gain_mode || i_gain_sel == idx_q) begin
            idx_q    <= i_gain_sel;
            state_q  <= S_IDLE;
            change_q <= 1'b0;
          end else if (cnt_q >= CNT_LAST) begin
            state_q <= S_STEP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q  <= S_IDLE;
          change_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_int        = int_q;
  assign o_sat_flag_p = sat_p_q;
  assign o_sat_flag_n = sat_n_q;
  assign o_vth_flag_p = vth_p_q;
  assign o_vth_flag_n = vth_n_q;
  assign o_change     = change_q;

`ifdef INT_VTH_V3_DBG_EN
  logic signed [ACC_W-1:0] dv_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dv_q <= '0;
    end else begin
      dv_q <= (i_en && !i_zero) ? ACC_W'(dv) : '0;
    end
  end

  assign o_dv        = dv_q;
  assign o_acc       = acc_q;
  assign o_shift_idx = idx_q;
  assign o_cstate    = state_q;
`endif

endmodule

// File: tb/tb_integrator_vth_v3.sv
// Scoreboard bench for integrator_vth_v3: directed stimulus queues expectations, a monitor checks them.
module tb_integrator_vth_v3;

  localparam int K_INT = 0;
  localparam int K_FLG = 1;
  localparam int K_CHG = 2;
  localparam logic [3:0] F_SATP = 4'b1000;
  localparam logic [3:0] F_SATN = 4'b0100;
  localparam logic [3:0] F_VTHP = 4'b0010;
  localparam logic [3:0] F_VTHN = 4'b0001;

  logic               clk;
  logic               rst_n;
  logic               en, zero, gain_mode, cut_mode, add_en;
  logic signed [31:0] err;
  logic        [4:0]  gain_sel;
  logic        [31:0] sat, vth;
  logic signed [31:0] ext;
  logic signed [31:0] o_int;
  logic               sat_p, sat_n, vth_p, vth_n, chg;

  integrator_vth_v3 #(
    .ERR_W(32), .ACC_W(32), .SHIFT_W(5), .RAMP_DIV(4)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_zero(zero), .i_err(err),
    .i_gain_sel(gain_sel), .i_gain_mode(gain_mode), .i_saturation(sat),
    .i_vth(vth), .i_vth_cut_mode(cut_mode), .i_add_sig_en(add_en),
    .i_ext_sig(ext), .o_int(o_int), .o_sat_flag_p(sat_p), .o_sat_flag_n(sat_n),
    .o_vth_flag_p(vth_p), .o_vth_flag_n(vth_n), .o_change(chg)
  );

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   acc_exp = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input string nm, input int kind, input int due, input logic [31:0] e);
    exp_t x;
    x.due = due; x.kind = kind; x.exp = e; x.name = nm;
    sbq.push_back(x);
  endtask

  always @(posedge clk) begin : monitor
    logic [31:0] act;
    #1;
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due == cyc) begin
        case (sbq[i].kind)
          K_INT:   act = o_int;
          K_FLG:   act = {28'd0, sat_p, sat_n, vth_p, vth_n};
          default: act = {31'd0, chg};
        endcase
        check(sbq[i].name, act, sbq[i].exp);
        sbq.delete(i);
      end
    end
  end

  // Inputs are already driven; expectations refer to the next edge (flags/change) and the one after (o_int).
  task automatic step_set(input string nm, input int acc_new, input logic [3:0] flg, input logic c);
    push({nm, ".flg"}, K_FLG, cyc + 1, {28'd0, flg});
    push({nm, ".chg"}, K_CHG, cyc + 1, {31'd0, c});
    push({nm, ".int"}, K_INT, cyc + 2, acc_new);
    acc_exp = acc_new;
    @(negedge clk);
  endtask

  task automatic step_chg(input string nm, input logic c);
    push({nm, ".flg"}, K_FLG, cyc + 1, 32'd0);
    push({nm, ".chg"}, K_CHG, cyc + 1, {31'd0, c});
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string nm);
    check({nm, ".int"}, o_int, 32'd0);
    check({nm, ".flg"}, {28'd0, sat_p, sat_n, vth_p, vth_n}, 32'd0);
    check({nm, ".chg"}, {31'd0, chg}, 32'd0);
  endtask

  int          t4_err[8] = '{5000, 5000, 5000, -5000, -5000, -5000, 1000, -1000};
  int          t4_acc[8] = '{1000, 2000, 3000, 2000, 1000, 0, 1000, 0};
  logic [3:0]  t4_flg[8] = '{F_SATP, F_SATP, F_SATP, F_SATN, F_SATN, F_SATN, 4'd0, 4'd0};
  int          pc_acc[7] = '{-20, -12, -4, 4, 12, 20, 20};
  logic [3:0]  pc_flg[7] = '{F_VTHN, 4'd0, 4'd0, 4'd0, 4'd0, F_VTHP, F_VTHP};
  int          r1_inc[8] = '{400, 400, 200, 200, 200, 200, 100, 100};
  logic        r1_chg[8] = '{1, 1, 1, 1, 1, 0, 0, 0};
  int          r2_inc[8] = '{400, 400, 200, 200, 200, 200, 400, 400};
  logic        r2_chg[8] = '{1, 1, 1, 1, 1, 0, 0, 0};
  int          r3_inc[4] = '{400, 400, 200, 50};
  logic        r3_chg[4] = '{1, 1, 0, 0};
  int          wn_acc[4] = '{-30, -10, -40, -20};
  logic [3:0]  wn_flg[4] = '{4'd0, F_VTHN, 4'd0, F_VTHN};

  initial begin
    rst_n = 1'b0; en = 1'b1; zero = 1'b0; err = 32'sd5; gain_sel = 5'd0;
    gain_mode = 1'b0; sat = 32'd1000; vth = 32'd10000; cut_mode = 1'b0;
    add_en = 1'b0; ext = 32'sd0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // Wrap at +threshold after 1000 steps of +10
    err = 32'sd10; en = 1'b1;
    for (int n = 1; n <= 1001; n++)
      step_set($sformatf("wrap%0d", n), (10 * n) % 10000, (n == 1000) ? F_VTHP : 4'd0, 1'b0);

    en = 1'b0;
    for (int n = 0; n < 3; n++) step_set($sformatf("hold%0d", n), 10, 4'd0, 1'b0);

    zero = 1'b1; en = 1'b1;
    step_set("zero_a", 0, 4'd0, 1'b0);
    zero = 1'b0; err = 32'sd700;
    step_set("acc700", 700, 4'd0, 1'b0);
    zero = 1'b1;
    step_set("zero700", 0, 4'd0, 1'b0);
    zero = 1'b0;

    for (int n = 0; n < 8; n++) begin
      err = t4_err[n];
      step_set($sformatf("sat%0d", n), t4_acc[n], t4_flg[n], 1'b0);
    end

    en = 1'b0; gain_sel = 5'd1; gain_mode = 1'b0;
    step_set("sel1", 0, 4'd0, 1'b0);
    en = 1'b1; cut_mode = 1'b1; err = -32'sd10;
    for (int n = 1; n <= 2003; n++)
      step_set($sformatf("clampn%0d", n), (n >= 2000) ? -10000 : -5 * n,
               (n >= 2000) ? F_VTHN : 4'd0, 1'b0);
    vth = 32'd20; err = 32'sd16;
    for (int n = 0; n < 7; n++) step_set($sformatf("clampp%0d", n), pc_acc[n], pc_flg[n], 1'b0);

    zero = 1'b1; gain_sel = 5'd0; cut_mode = 1'b0; vth = 32'd10000;
    step_set("zero_b", 0, 4'd0, 1'b0);
    zero = 1'b0; err = 32'sd20; en = 1'b1;
    push("ext_acc.flg", K_FLG, cyc + 1, 32'd0);
    @(negedge clk);
    en = 1'b0; add_en = 1'b1; ext = -32'sd3;
    push("ext_neg3", K_INT, cyc + 1, 32'd17);
    @(negedge clk);
    ext = 32'sh7FFFFFFF;
    push("ext_wrap", K_INT, cyc + 1, 32'h80000013);
    @(negedge clk);
    add_en = 1'b0; ext = 32'sd0;
    push("ext_off", K_INT, cyc + 1, 32'd20);
    @(negedge clk);
    acc_exp = 20;

    en = 1'b1; err = 32'sd400; gain_mode = 1'b1; gain_sel = 5'd2;
    for (int n = 0; n < 8; n++)
      step_set($sformatf("ramp_up%0d", n), acc_exp + r1_inc[n], 4'd0, r1_chg[n]);

    gain_mode = 1'b0; gain_sel = 5'd0;
    step_set("jump0", acc_exp + 100, 4'd0, 1'b0);
    gain_mode = 1'b1; gain_sel = 5'd2;
    for (int n = 0; n < 8; n++) begin
      if (n == 2) gain_sel = 5'd0;
      step_set($sformatf("retarget%0d", n), acc_exp + r2_inc[n], 4'd0, r2_chg[n]);
    end

    gain_sel = 5'd3;
    for (int n = 0; n < 4; n++) begin
      if (n == 2) gain_mode = 1'b0;
      step_set($sformatf("abort%0d", n), acc_exp + r3_inc[n], 4'd0, r3_chg[n]);
    end

    en = 1'b0; gain_mode = 1'b1; gain_sel = 5'd0;
    step_chg("ramp_rst0", 1'b1);
    step_chg("ramp_rst1", 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_state("async_rst");
    @(negedge clk);
    check_reset_state("rst_hold");
    rst_n = 1'b1; acc_exp = 0;

    en = 1'b1; err = 32'sd400; gain_mode = 1'b0;
    step_set("post_rst", 400, 4'd0, 1'b0);

    zero = 1'b1;
    step_set("zero_c", 0, 4'd0, 1'b0);
    zero = 1'b0; vth = 32'd50; err = -32'sd30;
    for (int n = 0; n < 4; n++) step_set($sformatf("wrapn%0d", n), wn_acc[n], wn_flg[n], 1'b0);

    en = 1'b0;
    repeat (3) @(negedge clk);
    while (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL unchecked %s: due cycle %0d, now %0d", sbq[0].name, sbq[0].due, cyc);
      sbq.delete(0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
